song_reader: RTL

//  Sequencer directly upstream of note_player. Walks the selected song in an external

---
 rtl/song_reader_pkg.sv | 42 ++++
 rtl/song_reader_if.sv | 40 ++++
 rtl/song_reader.sv | 107 ++++++++++
 3 files changed

// File: rtl/song_reader_pkg.sv
// Song reader shared constants, FSM state encoding and song ROM word helpers.
// Also used by the song ROM and the bench to pack/unpack {note, duration} words.
package song_reader_pkg;

    localparam int SONG_BITS   = 2;
    localparam int IDX_BITS    = 5;
    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int ROM_LATENCY = 1;

    localparam int ADDR_W = SONG_BITS + IDX_BITS;
    localparam int WORD_W = NOTE_W + DUR_W;
    localparam int LAT_W  = $clog2(ROM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_PLAYING = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic [NOTE_W-1:0] rom_note(
        input logic [WORD_W-1:0] w
    );
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] rom_dur(
        input logic [WORD_W-1:0] w
    );
        return w[DUR_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] rom_word(
        input logic [NOTE_W-1:0] n,
        input logic [DUR_W-1:0]  d
    );
        return {n, d};
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Bundle between the song reader, its song ROM and note_player.
// master = song reader side, slave = environment (ROM, player, control).
interface song_reader_if;
    import song_reader_pkg::*;

    logic                  play;
    logic [SONG_BITS-1:0]  song;
    logic                  note_done;
    logic [ADDR_W-1:0]     rom_addr;
    logic [WORD_W-1:0]     rom_data;
    logic [NOTE_W-1:0]     note;
    logic [DUR_W-1:0]      duration;
    logic                  new_note;
    logic                  song_done;

    modport master (
        input  play,
        input  song,
        input  note_done,
        input  rom_data,
        output rom_addr,
        output note,
        output duration,
        output new_note,
        output song_done
    );

    modport slave (
        output play,
        output song,
        output note_done,
        output rom_data,
        input  rom_addr,
        input  note,
        input  duration,
        input  new_note,
        input  song_done
    );

endinterface

// File: rtl/song_reader.sv
// Walks the selected song in the song ROM and hands each {note, duration}
// entry to note_player with a one-cycle load strobe.
module song_reader
    import song_reader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SONG_BITS-1:0]  r_song_q;
    logic [IDX_BITS-1:0]   r_idx;
    logic [IDX_BITS-1:0]   w_idx_nxt;
    logic [NOTE_W-1:0]     r_note;
    logic [NOTE_W-1:0]     w_note_nxt;
    logic [DUR_W-1:0]      r_dur;
    logic [DUR_W-1:0]      w_dur_nxt;
    logic [LAT_W-1:0]      r_lat;
    logic [LAT_W-1:0]      w_lat_nxt;
    logic                  w_new_note;
    logic                  w_song_chg;

    assign w_song_chg = (bus.song != r_song_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_song_q <= '0;
            r_idx    <= '0;
            r_note   <= '0;
            r_dur    <= '0;
            r_lat    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_song_q <= bus.song;
            r_idx    <= w_idx_nxt;
            r_note   <= w_note_nxt;
            r_dur    <= w_dur_nxt;
            r_lat    <= w_lat_nxt;
        end
    end

    // A song change wins over everything, even while paused.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_note_nxt  = r_note;
        w_dur_nxt   = r_dur;
        w_lat_nxt   = r_lat;
        w_new_note  = 1'b0;
        if (w_song_chg) begin
            w_state_nxt = bus.play ? S_FETCH : S_IDLE;
            w_idx_nxt   = '0;
            w_lat_nxt   = '0;
        end else if (bus.play) begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FETCH;
                    w_lat_nxt   = '0;
                end
                S_FETCH: begin
                    if (r_lat == LAT_W'(ROM_LATENCY)) begin
                        w_note_nxt  = rom_note(bus.rom_data);
                        w_dur_nxt   = rom_dur(bus.rom_data);
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_lat_nxt = r_lat + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_dur == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_new_note  = 1'b1;
                        w_state_nxt = S_PLAYING;
                    end
                end
                S_PLAYING: begin
                    if (bus.note_done) begin
                        if (&r_idx) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_lat_nxt   = '0;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr  = {r_song_q, r_idx};
    assign bus.note      = r_note;
    assign bus.duration  = r_dur;
    assign bus.new_note  = w_new_note;
    assign bus.song_done = (r_state == S_DONE);

endmodule
